// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: dual-slot push, single pop, single-cycle flush.
// Optional INST_QUEUE_BYPASS_EN forwards slot 0 straight to decode when the queue is empty.
module inst_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic [1:0]                   fetch_valid,
  input  logic [31:0]                  fetch_pc0,
  input  logic [31:0]                  fetch_pc1,
  input  logic [31:0]                  fetch_inst0,
  input  logic [31:0]                  fetch_inst1,
  input  logic                         fetch_err0,
  input  logic                         fetch_err1,
  output logic                         fetch_ready,
  output logic                         out_valid,
  output logic [31:0]                  out_pc,
  output logic [31:0]                  out_inst,
  output logic                         out_err,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic          err_q  [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    valid_m;
  logic          push_ok;
  logic          byp;
  logic          byp_take;
  logic          pop;
  logic [1:0]    nwr;
  logic          nrd;
  logic          wr0_en, wr1_en;
  logic [AW-1:0] wr0_idx, wr1_idx;
  logic [31:0]   wr0_pc, wr0_inst;
  logic          wr0_err;

  always_comb begin
    valid_m     = (fetch_valid == 2'b10) ? 2'b00 : fetch_valid;
    fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);
    push_ok     = fetch_ready && (valid_m != 2'b00) && !flush;

`ifdef INST_QUEUE_BYPASS_EN
    byp = resetn && (count_q == '0) && valid_m[0] && fetch_ready && !flush;
`else
    byp = 1'b0;
`endif
    byp_take = byp && out_ready;

    out_valid = ((count_q != '0) && !flush) || byp;
    out_pc    = byp ? fetch_pc0   : pc_q[head_q];
    out_inst  = byp ? fetch_inst0 : inst_q[head_q];
    out_err   = byp ? fetch_err0  : err_q[head_q];
    pop       = out_valid && out_ready && !flush;

    wr0_en   = 1'b0;
    wr1_en   = 1'b0;
    wr0_idx  = tail_q;
    wr1_idx  = tail_q + AW'(1);
    wr0_pc   = fetch_pc0;
    wr0_inst = fetch_inst0;
    wr0_err  = fetch_err0;
    nwr      = 2'd0;
    // A bypassed slot 0 never enters storage, so slot 1 takes its place at tail.
    if (byp_take) begin
      wr0_en   = valid_m[1];
      wr0_pc   = fetch_pc1;
      wr0_inst = fetch_inst1;
      wr0_err  = fetch_err1;
      nwr      = {1'b0, valid_m[1]};
    end else if (push_ok) begin
      wr0_en = 1'b1;
      wr1_en = valid_m[1];
      nwr    = valid_m[1] ? 2'd2 : 2'd1;
    end
    nrd = pop && !byp_take;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(nrd);
      tail_d  = tail_q + AW'(nwr);
      count_d = count_q + CW'(nwr) - CW'(nrd);
    end
    count = count_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        err_q[i]  <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (wr0_en && !flush) begin
        pc_q[wr0_idx]   <= wr0_pc;
        inst_q[wr0_idx] <= wr0_inst;
        err_q[wr0_idx]  <= wr0_err;
      end
      if (wr1_en && !flush) begin
        pc_q[wr1_idx]   <= fetch_pc1;
        inst_q[wr1_idx] <= fetch_inst1;
        err_q[wr1_idx]  <= fetch_err1;
      end
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus queues expected entries, a negedge monitor checks each pop.
module tb_inst_queue;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_pc0, fetch_pc1, fetch_inst0, fetch_inst1;
  logic        fetch_err0, fetch_err1;
  logic        fetch_ready;
  logic        out_valid;
  logic [31:0] out_pc, out_inst;
  logic        out_err;
  logic        out_ready;
  logic [3:0]  count;

  int unsigned tests  = 0;
  int unsigned failed = 0;
  entry_t      sb[$];
  entry_t      mon_e;

  inst_queue #(.DEPTH(8)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .fetch_valid(fetch_valid),
    .fetch_pc0(fetch_pc0), .fetch_pc1(fetch_pc1),
    .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
    .fetch_err0(fetch_err0), .fetch_err1(fetch_err1),
    .fetch_ready(fetch_ready), .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_err(out_err), .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  function void check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic entry_t mk(logic [31:0] pc, logic err);
    entry_t e;
    e.pc   = pc;
    e.inst = pc ^ 32'hA5A5_0000;
    e.err  = err;
    return e;
  endfunction

  // Monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn && out_valid && out_ready && !flush) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL spurious_out: got pc %h expected no output", out_pc);
      end else begin
        mon_e = sb.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("out_inst", out_inst, mon_e.inst);
        check("out_err", {31'b0, out_err}, {31'b0, mon_e.err});
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered and left at posedge+1; waits (bounded) for fetch_ready before pushing.
  task automatic push(input logic [1:0] v, input entry_t e0, input entry_t e1, input bit rnd);
    int unsigned waited = 0;
    bit done = 1'b0;
    fetch_valid = v;
    fetch_pc0 = e0.pc; fetch_inst0 = e0.inst; fetch_err0 = e0.err;
    fetch_pc1 = e1.pc; fetch_inst1 = e1.inst; fetch_err1 = e1.err;
    while (!done) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      if (fetch_ready) begin
        sb.push_back(e0);
        if (v == 2'b11) sb.push_back(e1);
        done = 1'b1;
      end else if (waited >= 200) begin
        tests++;
        failed++;
        $display("FAIL push_timeout: got fetch_ready 0 for %0d cycles expected 1", waited);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    fetch_valid = 2'b00;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 32'(sb.size()), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; fetch_valid = 2'b00; out_ready = 1'b0;
    fetch_pc0 = '0; fetch_pc1 = '0; fetch_inst0 = '0; fetch_inst1 = '0;
    fetch_err0 = 1'b0; fetch_err1 = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", {31'b0, out_err}, 32'd0);
    check("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible one cycle later
    push(2'b01, mk(32'hBFC0_0000, 1'b0), mk(32'h0, 1'b0), 1'b0);
    check("single_valid", {31'b0, out_valid}, 32'd1);
    check("single_pc", out_pc, 32'hBFC0_0000);
    check("single_inst", out_inst, 32'hBFC0_0000 ^ 32'hA5A5_0000);
    check("single_count", 32'(count), 32'd1);
    drain();

    // Illegal mask 2'b10 pushes nothing
    fetch_valid = 2'b10; fetch_pc0 = 32'h0000_0DEA; fetch_pc1 = 32'h0000_0DEB;
    idle(1);
    fetch_valid = 2'b00;
    check("illegal_count", 32'(count), 32'd0);
    check("illegal_valid", {31'b0, out_valid}, 32'd0);

    // Dual push with continuous pop: order and peak occupancy
    out_ready = 1'b1;
    push(2'b11, mk(32'h100, 1'b0), mk(32'h104, 1'b1), 1'b0);
    push(2'b11, mk(32'h108, 1'b1), mk(32'h10C, 1'b0), 1'b0);
`ifdef INST_QUEUE_BYPASS_EN
    check("dual_peak", 32'(count), 32'd2);
`else
    check("dual_peak", 32'(count), 32'd3);
`endif
    drain();

    // Fill to DEPTH with no pops, then a single pop
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("full_ready_before", {31'b0, fetch_ready}, 32'd1);
      push(2'b11, mk(32'h300 + 32'(16 * k), k[0]), mk(32'h308 + 32'(16 * k), ~k[0]), 1'b0);
    end
    check("full_count", 32'(count), 32'd8);
    check("full_ready", {31'b0, fetch_ready}, 32'd0);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("pop7_count", 32'(count), 32'd7);
    check("pop7_ready", {31'b0, fetch_ready}, 32'd0);
    drain();

    // Wrap-around with random backpressure
    for (int k = 0; k < 40; k++) begin
      push(2'b11, mk(32'h1000 + 32'(8 * k), 1'($urandom_range(0, 1))),
           mk(32'h1004 + 32'(8 * k), 1'($urandom_range(0, 1))), 1'b1);
    end
    drain();

    // Flush while pushing and popping
    out_ready = 1'b0;
    push(2'b11, mk(32'h400, 1'b0), mk(32'h404, 1'b0), 1'b0);
    push(2'b11, mk(32'h408, 1'b0), mk(32'h40C, 1'b0), 1'b0);
    push(2'b01, mk(32'h410, 1'b1), mk(32'h0, 1'b0), 1'b0);
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1; out_ready = 1'b1;
    fetch_valid = 2'b11; fetch_pc0 = 32'h500; fetch_pc1 = 32'h504;
    @(negedge clk);
    check("flush_valid_same", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; fetch_valid = 2'b00; out_ready = 1'b0;
    sb.delete();
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid_next", {31'b0, out_valid}, 32'd0);
    check("flush_ready", {31'b0, fetch_ready}, 32'd1);
    push(2'b01, mk(32'h200, 1'b0), mk(32'h0, 1'b0), 1'b0);
    check("post_flush_pc", out_pc, 32'h200);
    push(2'b11, mk(32'h204, 1'b1), mk(32'h208, 1'b0), 1'b0);
    drain();

    // Asynchronous reset between edges
    push(2'b11, mk(32'h600, 1'b0), mk(32'h604, 1'b0), 1'b0);
    push(2'b11, mk(32'h608, 1'b0), mk(32'h60C, 1'b0), 1'b0);
    check("pre_reset_count", 32'(count), 32'd4);
    #2;
    resetn = 1'b0;
    #1;
    check("async_valid", {31'b0, out_valid}, 32'd0);
    check("async_count", 32'(count), 32'd0);
    check("async_ready", {31'b0, fetch_ready}, 32'd1);
    sb.delete();
    @(negedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_count", 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
